// File: rtl/reg_access_controller_pkg.sv
// rtl/reg_access_controller_pkg.sv - shared packet type, FSM states and defaults for reg_access_controller
// Optional feature macro: REG_ACCESS_WRITE_ACK_EN (adds the ST_W_ACK state).
package reg_access_controller_pkg;

    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic       SoP;
        logic       EoP;
        logic       Valid;
        logic [7:0] Data;
    } UART_PACKET;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_R_ADDR,
        ST_R_COUNT,
        ST_R_FETCH,
        ST_R_WAIT,
        ST_SEND,
        ST_W_ADDR,
        ST_W_DATA,
        ST_DROP
`ifdef REG_ACCESS_WRITE_ACK_EN
        , ST_W_ACK
`endif
    } state_t;

    localparam logic [7:0] READ_DEST_DEFAULT  = 8'h00;
    localparam logic [7:0] WRITE_DEST_DEFAULT = 8'h01;
    localparam logic [7:0] LOCAL_ID_DEFAULT   = 8'h10;

    // Requested word count: 0 means one word, anything above the limit saturates.
    function automatic int unsigned clamp_count(input logic [7:0] req, input int unsigned max_burst);
        if (req == 8'd0) return 1;
        if (32'(req) > max_burst) return max_burst;
        return 32'(req);
    endfunction

endpackage

// File: rtl/tx_word_serialiser.sv
// rtl/tx_word_serialiser.sv - emits a loaded word LSB-first as bytes under tvalid/tready
// Ports: clk, resetn (sync, active-low); load/load_word/load_bytes/load_sop/load_eop start a word;
//        tready in, tvalid/tdata/tsop/tlast out; done pulses when the final byte is accepted.
module tx_word_serialiser #(
    parameter int DATA_WIDTH = 32,
    parameter int CW         = $clog2(DATA_WIDTH / 8 + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_word,
    input  logic [CW-1:0]         load_bytes,
    input  logic                  load_sop,
    input  logic                  load_eop,
    input  logic                  tready,
    output logic                  tvalid,
    output logic [7:0]            tdata,
    output logic                  tsop,
    output logic                  tlast,
    output logic                  done
);

    logic [DATA_WIDTH-1:0] shift;
    logic [CW-1:0]         remaining;
    logic                  sop_q;
    logic                  eop_q;
    logic                  last_byte;

    assign last_byte = (remaining == CW'(1));
    assign tdata     = shift[7:0];
    assign tsop      = tvalid & sop_q;
    // EoP qualifies only the final byte of a word flagged as packet end.
    assign tlast     = tvalid & eop_q & last_byte;
    assign done      = tvalid & tready & last_byte;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            shift     <= '0;
            remaining <= '0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            tvalid    <= 1'b0;
        end else if (load) begin
            shift     <= load_word;
            remaining <= load_bytes;
            sop_q     <= load_sop;
            eop_q     <= load_eop;
            tvalid    <= 1'b1;
        end else if (tvalid && tready) begin
            shift     <= shift >> 8;
            remaining <= remaining - CW'(1);
            sop_q     <= 1'b0;
            if (last_byte) tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_access_controller.sv
// rtl/reg_access_controller.sv - decodes request packets into burst register reads/writes and serialises read replies
// Optional feature macro: REG_ACCESS_WRITE_ACK_EN (1-byte write acknowledge reply).
// Ports: ipClk, ipReset (sync, active-low); ipRxStream request bytes; ipTxReady/opTxStream reply bytes;
//        opAddress, ipReadData (valid one cycle after opAddress), opWriteData, opWrite strobe; opBusy.
module reg_access_controller
    import reg_access_controller_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter int         ADDR_WIDTH = 8,
    parameter int         MAX_BURST  = 16,
    parameter logic [7:0] READ_DEST  = READ_DEST_DEFAULT,
    parameter logic [7:0] WRITE_DEST = WRITE_DEST_DEFAULT,
    parameter logic [7:0] LOCAL_ID   = LOCAL_ID_DEFAULT
) (
    input  logic                  ipClk,
    input  logic                  ipReset,
    input  UART_PACKET            ipRxStream,
    input  logic                  ipTxReady,
    output UART_PACKET            opTxStream,
    output logic [ADDR_WIDTH-1:0] opAddress,
    input  logic [DATA_WIDTH-1:0] ipReadData,
    output logic [DATA_WIDTH-1:0] opWriteData,
    output logic                  opWrite,
    output logic                  opBusy
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CW    = $clog2(BYTES + 1);
    localparam int CBW   = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  BYTES_W  = CW'(BYTES);
    localparam logic [CW-1:0]  BYTES_M1 = CW'(BYTES - 1);
    localparam logic [CBW-1:0] MAX_W    = CBW'(MAX_BURST);

    state_t                state, next_state;
    logic [7:0]            src_lat;
    logic [ADDR_WIDTH-1:0] base;
    logic [CBW-1:0]        count;
    logic [CBW-1:0]        word;
    logic [7:0]            len;
    logic [CW-1:0]         byte_cnt;
    logic [DATA_WIDTH-1:0] assembly;
    logic [DATA_WIDTH-1:0] asm_next;

    logic                  rx_state, hdr, wbyte, word_done, last_word;
    logic                  ser_load, ser_sop, ser_eop, ser_done;
    logic [DATA_WIDTH-1:0] ser_word;
    logic [CW-1:0]         ser_bytes;
    logic                  tx_valid, tx_sop, tx_eop;
    logic [7:0]            tx_data;
    logic                  unused_rx;
`ifdef REG_ACCESS_WRITE_ACK_EN
    logic                  ack_start;
    logic [CBW-1:0]        ack_count;
`endif

    assign unused_rx = ^ipRxStream.Length;
    assign opBusy    = (state != ST_IDLE);
    assign last_word = (word == count - CBW'(1));
    assign asm_next  = DATA_WIDTH'({ipRxStream.Data, assembly} >> 8);

    always_ff @(posedge ipClk) begin
        if (!ipReset) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        ser_load   = 1'b0;
        ser_word   = ipReadData;
        ser_bytes  = BYTES_W;
        ser_sop    = (word == '0);
        ser_eop    = last_word;
        rx_state   = state inside {ST_IDLE, ST_R_ADDR, ST_R_COUNT, ST_W_ADDR, ST_W_DATA, ST_DROP};
        // A SoP byte restarts decoding from any state that listens to Rx.
        hdr        = rx_state && ipRxStream.Valid && ipRxStream.SoP;
        wbyte      = (state == ST_W_DATA) && ipRxStream.Valid && !hdr && (word < MAX_W);
        word_done  = wbyte && (byte_cnt == BYTES_M1);
`ifdef REG_ACCESS_WRITE_ACK_EN
        ack_start  = 1'b0;
        ack_count  = word + (word_done ? CBW'(1) : CBW'(0));
`endif
        if (hdr) begin
            if (ipRxStream.EoP)                           next_state = ST_IDLE;
            else if (ipRxStream.Destination == READ_DEST)  next_state = ST_R_ADDR;
            else if (ipRxStream.Destination == WRITE_DEST) next_state = ST_W_ADDR;
            else                                           next_state = ST_DROP;
        end else if (rx_state && ipRxStream.Valid) begin
            case (state)
                ST_R_ADDR:  next_state = ipRxStream.EoP ? ST_IDLE : ST_R_COUNT;
                ST_R_COUNT: next_state = ipRxStream.EoP ? ST_IDLE : ST_R_FETCH;
                ST_W_ADDR:  next_state = ipRxStream.EoP ? ST_IDLE : ST_W_DATA;
                ST_W_DATA: begin
                    if (ipRxStream.EoP) begin
`ifdef REG_ACCESS_WRITE_ACK_EN
                        next_state = ST_W_ACK;
                        ack_start  = 1'b1;
                        ser_load   = 1'b1;
                        ser_word   = DATA_WIDTH'(ack_count);
                        ser_bytes  = CW'(1);
                        ser_sop    = 1'b1;
                        ser_eop    = 1'b1;
`else
                        next_state = ST_IDLE;
`endif
                    end
                end
                ST_DROP:    if (ipRxStream.EoP) next_state = ST_IDLE;
                default: ;
            endcase
        end
        case (state)
            ST_R_FETCH: next_state = ST_R_WAIT;
            ST_R_WAIT: begin
                // ipReadData now reflects the address driven during R_FETCH.
                next_state = ST_SEND;
                ser_load   = 1'b1;
            end
            ST_SEND:    if (ser_done) next_state = last_word ? ST_IDLE : ST_R_FETCH;
`ifdef REG_ACCESS_WRITE_ACK_EN
            ST_W_ACK:   if (ser_done) next_state = ST_IDLE;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge ipClk) begin
        if (!ipReset) begin
            src_lat     <= '0;
            base        <= '0;
            count       <= '0;
            len         <= '0;
            word        <= '0;
            byte_cnt    <= '0;
            assembly    <= '0;
            opAddress   <= '0;
            opWriteData <= '0;
            opWrite     <= 1'b0;
        end else begin
            opWrite <= 1'b0;
            if (hdr) begin
                src_lat  <= ipRxStream.Source;
                word     <= '0;
                byte_cnt <= '0;
            end else if (ipRxStream.Valid) begin
                case (state)
                    ST_R_ADDR, ST_W_ADDR: base <= ADDR_WIDTH'(ipRxStream.Data);
                    ST_R_COUNT: begin
                        if (!ipRxStream.EoP) begin
                            count     <= CBW'(clamp_count(ipRxStream.Data, MAX_BURST));
                            len       <= 8'(clamp_count(ipRxStream.Data, MAX_BURST) * BYTES);
                            opAddress <= base;
                        end
                    end
                    default: ;
                endcase
            end
            if (wbyte) begin
                assembly <= asm_next;
                if (word_done) begin
                    opWrite     <= 1'b1;
                    opAddress   <= base + ADDR_WIDTH'(word);
                    opWriteData <= asm_next;
                    word        <= word + CBW'(1);
                    byte_cnt    <= '0;
                end else begin
                    byte_cnt <= byte_cnt + CW'(1);
                end
            end
            if (state == ST_SEND && ser_done && !last_word) begin
                word      <= word + CBW'(1);
                opAddress <= base + ADDR_WIDTH'(word + CBW'(1));
            end
`ifdef REG_ACCESS_WRITE_ACK_EN
            if (ack_start) len <= 8'd1;
`endif
        end
    end

    tx_word_serialiser #(
        .DATA_WIDTH (DATA_WIDTH),
        .CW         (CW)
    ) u_ser (
        .clk        (ipClk),
        .resetn     (ipReset),
        .load       (ser_load),
        .load_word  (ser_word),
        .load_bytes (ser_bytes),
        .load_sop   (ser_sop),
        .load_eop   (ser_eop),
        .tready     (ipTxReady),
        .tvalid     (tx_valid),
        .tdata      (tx_data),
        .tsop       (tx_sop),
        .tlast      (tx_eop),
        .done       (ser_done)
    );

    // Header fields are zeroed while idle so the stream is all-zero out of reset.
    always_comb begin
        opTxStream = '0;
        if (tx_valid) begin
            opTxStream.Valid       = 1'b1;
            opTxStream.SoP         = tx_sop;
            opTxStream.EoP         = tx_eop;
            opTxStream.Data        = tx_data;
            opTxStream.Source      = LOCAL_ID;
            opTxStream.Destination = src_lat;
            opTxStream.Length      = len;
        end
    end

endmodule

// File: tb/tb_reg_access_controller.sv
// tb/tb_reg_access_controller.sv - directed self-checking bench for reg_access_controller
module tb_reg_access_controller;
    import reg_access_controller_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    UART_PACKET  rx;
    logic        tx_ready;
    UART_PACKET  tx;
    logic [7:0]  addr;
    logic [31:0] rd_data;
    logic [31:0] wr_data;
    logic        wr;
    logic        busy;

    int errors = 0;
    int checks = 0;

    UART_PACKET  txq[$];
    logic [39:0] wrq[$];

    always #5 clk = ~clk;

    reg_access_controller dut (
        .ipClk       (clk),
        .ipReset     (resetn),
        .ipRxStream  (rx),
        .ipTxReady   (tx_ready),
        .opTxStream  (tx),
        .opAddress   (addr),
        .ipReadData  (rd_data),
        .opWriteData (wr_data),
        .opWrite     (wr),
        .opBusy      (busy)
    );

    function automatic logic [31:0] reg_word(input logic [7:0] a);
        if (a == 8'h11) return 32'h76543210;
        return {a ^ 8'hC3, a ^ 8'h3C, ~a, a};
    endfunction

    function automatic UART_PACKET exp_byte(input logic [7:0] dst, input logic [7:0] ln,
                                            input logic sop, input logic eop, input logic [7:0] d);
        UART_PACKET p;
        p = '0;
        p.Source = 8'h10; p.Destination = dst; p.Length = ln;
        p.SoP = sop; p.EoP = eop; p.Valid = 1'b1; p.Data = d;
        return p;
    endfunction

    // Register file model: read data follows the address by one cycle.
    always @(posedge clk) rd_data <= reg_word(addr);

    always @(negedge clk) begin
        if (tx.Valid === 1'b1 && tx_ready === 1'b1) txq.push_back(tx);
        if (wr === 1'b1) wrq.push_back({addr, wr_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic sop, input logic eop, input logic [7:0] dst,
                             input logic [7:0] src, input logic [7:0] d);
        rx = '0;
        rx.Valid = 1'b1; rx.SoP = sop; rx.EoP = eop;
        rx.Destination = dst; rx.Source = src; rx.Data = d;
        tick();
        rx = '0;
    endtask

    task automatic send_read(input logic [7:0] src, input logic [7:0] a, input logic [7:0] cnt);
        send_byte(1'b1, 1'b0, 8'h00, src, 8'h00);
        send_byte(1'b0, 1'b0, 8'h00, src, a);
        send_byte(1'b0, 1'b0, 8'h00, src, cnt);
        send_byte(1'b0, 1'b1, 8'h00, src, 8'h00);
    endtask

    task automatic wait_tx(input int n, input int limit, input bit toggle, input string name);
        int k = 0;
        while (txq.size() < n && k < limit) begin
            if (toggle) tx_ready = ~tx_ready;
            tick();
            k++;
        end
        tx_ready = 1'b1;
        checks++;
        if (txq.size() < n) begin
            errors++;
            $display("FAIL %s: timeout with %0d bytes, required %0d", name, txq.size(), n);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; rx = '0; tx_ready = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        checks++; if (tx !== '0) begin errors++; $display("FAIL reset_tx: got %h required 0", tx); end
        checks++; if (addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h required 00", addr); end
        checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h required 0", wr_data); end
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_write: got %b required 0", wr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    endtask

    task automatic test_single_read();
        logic [31:0] w = 32'h76543210;
        UART_PACKET e;
        txq.delete(); tx_ready = 1'b1;
        send_byte(1'b1, 1'b0, 8'h00, 8'h22, 8'h00);
        send_byte(1'b0, 1'b0, 8'h00, 8'h22, 8'h11);
        send_byte(1'b0, 1'b0, 8'h00, 8'h22, 8'h01);
        checks++; if (addr !== 8'h11) begin errors++; $display("FAIL single_addr: got %h required 11", addr); end
        send_byte(1'b0, 1'b1, 8'h00, 8'h22, 8'h00);
        checks++; if (tx.Valid !== 1'b0) begin errors++; $display("FAIL single_early: valid %b required 0", tx.Valid); end
        tick();
        e = exp_byte(8'h22, 8'h04, 1'b1, 1'b0, 8'h10);
        checks++; if (tx !== e) begin errors++; $display("FAIL single_latency: got %h required %h", tx, e); end
        wait_tx(4, 40, 1'b0, "single_wait");
        for (int i = 0; i < 4 && i < txq.size(); i++) begin
            e = exp_byte(8'h22, 8'h04, i == 0, i == 3, w[8*i +: 8]);
            checks++; if (txq[i] !== e) begin errors++; $display("FAIL single_byte%0d: got %h required %h", i, txq[i], e); end
        end
    endtask

    task automatic test_burst_backpressure();
        UART_PACKET e;
        logic [7:0] a;
        logic [31:0] w;
        txq.delete(); tx_ready = 1'b1;
        send_read(8'h33, 8'hFE, 8'h03);
        wait_tx(12, 300, 1'b1, "burst_wait");
        repeat (6) tick();
        checks++; if (txq.size() != 12) begin errors++; $display("FAIL burst_count: got %0d bytes required 12", txq.size()); end
        for (int i = 0; i < 12 && i < txq.size(); i++) begin
            a = 8'hFE + 8'(i / 4);
            w = reg_word(a);
            e = exp_byte(8'h33, 8'h0C, i == 0, i == 11, w[8*(i%4) +: 8]);
            checks++; if (txq[i] !== e) begin errors++; $display("FAIL burst_byte%0d: got %h required %h", i, txq[i], e); end
        end
        checks++; if (addr !== 8'h00) begin errors++; $display("FAIL burst_wrap: addr %h required 00", addr); end
    endtask

    task automatic test_write_burst();
        UART_PACKET e;
        txq.delete(); wrq.delete(); tx_ready = 1'b1;
        send_byte(1'b1, 1'b0, 8'h01, 8'h44, 8'h00);
        send_byte(1'b0, 1'b0, 8'h01, 8'h44, 8'h20);
        for (int i = 1; i <= 8; i++) send_byte(1'b0, i == 8, 8'h01, 8'h44, 8'(i));
        repeat (8) tick();
        checks++; if (wrq.size() != 2) begin errors++; $display("FAIL write_count: got %0d writes required 2", wrq.size()); end
        if (wrq.size() >= 2) begin
            checks++; if (wrq[0] !== 40'h20_04030201) begin errors++; $display("FAIL write0: got %h required 2004030201", wrq[0]); end
            checks++; if (wrq[1] !== 40'h21_08070605) begin errors++; $display("FAIL write1: got %h required 2108070605", wrq[1]); end
        end
`ifdef REG_ACCESS_WRITE_ACK_EN
        e = exp_byte(8'h44, 8'h01, 1'b1, 1'b1, 8'h02);
        checks++; if (txq.size() != 1 || txq[0] !== e) begin errors++; $display("FAIL write_ack: got %0d bytes first %h required %h", txq.size(), txq.size() ? txq[0] : '0, e); end
`else
        e = '0;
        checks++; if (txq.size() != 0) begin errors++; $display("FAIL write_noreply: got %0d bytes required 0 (%h)", txq.size(), e); end
`endif
    endtask

    task automatic test_malformed();
        UART_PACKET e;
        logic [31:0] w;
        // Write ending after 6 data bytes: only the full first word lands.
        txq.delete(); wrq.delete(); tx_ready = 1'b1;
        send_byte(1'b1, 1'b0, 8'h01, 8'h44, 8'h00);
        send_byte(1'b0, 1'b0, 8'h01, 8'h44, 8'h30);
        for (int i = 1; i <= 6; i++) send_byte(1'b0, i == 6, 8'h01, 8'h44, 8'(i));
        repeat (6) tick();
        checks++; if (wrq.size() != 1 || wrq[0] !== 40'h30_04030201) begin errors++; $display("FAIL partial_write: got %0d writes first %h required 1 x 3004030201", wrq.size(), wrq.size() ? wrq[0] : 40'h0); end
`ifdef REG_ACCESS_WRITE_ACK_EN
        e = exp_byte(8'h44, 8'h01, 1'b1, 1'b1, 8'h01);
        checks++; if (txq.size() != 1 || txq[0] !== e) begin errors++; $display("FAIL partial_ack: got %0d bytes required %h", txq.size(), e); end
`endif
        // Count 0 reads one word.
        txq.delete();
        send_read(8'h55, 8'h60, 8'h00);
        wait_tx(4, 40, 1'b0, "count0_wait");
        repeat (6) tick();
        checks++; if (txq.size() != 4) begin errors++; $display("FAIL count0_size: got %0d bytes required 4", txq.size()); end
        w = reg_word(8'h60);
        for (int i = 0; i < 4 && i < txq.size(); i++) begin
            e = exp_byte(8'h55, 8'h04, i == 0, i == 3, w[8*i +: 8]);
            checks++; if (txq[i] !== e) begin errors++; $display("FAIL count0_byte%0d: got %h required %h", i, txq[i], e); end
        end
        // Count 0x40 clamps to 16 words.
        txq.delete();
        send_read(8'h66, 8'h80, 8'h40);
        wait_tx(64, 600, 1'b0, "clamp_wait");
        repeat (8) tick();
        checks++; if (txq.size() != 64) begin errors++; $display("FAIL clamp_size: got %0d bytes required 64", txq.size()); end
        for (int i = 0; i < 64 && i < txq.size(); i++) begin
            w = reg_word(8'h80 + 8'(i / 4));
            e = exp_byte(8'h66, 8'h40, i == 0, i == 63, w[8*(i%4) +: 8]);
            checks++; if (txq[i] !== e) begin errors++; $display("FAIL clamp_byte%0d: got %h required %h", i, txq[i], e); end
        end
        // Unknown destination is dropped without side effects.
        txq.delete(); wrq.delete();
        send_byte(1'b1, 1'b0, 8'h07, 8'h77, 8'h00);
        send_byte(1'b0, 1'b0, 8'h07, 8'h77, 8'h12);
        send_byte(1'b0, 1'b0, 8'h07, 8'h77, 8'h01);
        send_byte(1'b0, 1'b1, 8'h07, 8'h77, 8'h55);
        repeat (6) tick();
        checks++; if (wrq.size() != 0 || txq.size() != 0) begin errors++; $display("FAIL drop_outputs: got %0d writes %0d bytes required 0", wrq.size(), txq.size()); end
        checks++; if (addr !== 8'h8F) begin errors++; $display("FAIL drop_addr: got %h required 8F", addr); end
    endtask

    task automatic test_reset_mid_send();
        UART_PACKET e;
        logic [31:0] w = 32'h76543210;
        txq.delete(); tx_ready = 1'b1;
        send_read(8'h77, 8'h50, 8'h02);
        wait_tx(2, 40, 1'b0, "midreset_wait");
        resetn = 1'b0;
        tick();
        checks++; if (tx.Valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b required 0", tx.Valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b required 0", busy); end
        resetn = 1'b1;
        repeat (2) tick();
        txq.delete();
        send_read(8'h22, 8'h11, 8'h01);
        wait_tx(4, 40, 1'b0, "postreset_wait");
        repeat (6) tick();
        checks++; if (txq.size() != 4) begin errors++; $display("FAIL postreset_size: got %0d bytes required 4", txq.size()); end
        for (int i = 0; i < 4 && i < txq.size(); i++) begin
            e = exp_byte(8'h22, 8'h04, i == 0, i == 3, w[8*i +: 8]);
            checks++; if (txq[i] !== e) begin errors++; $display("FAIL postreset_byte%0d: got %h required %h", i, txq[i], e); end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_burst_backpressure();
        test_write_burst();
        test_malformed();
        test_reset_mid_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
